// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down counter with wrap, saturate and one-shot modes
module param_updown_counter #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, step;
    logic             tc_q, tc_d, busy_q, busy_d, done_q, done_d;
    logic             at_bnd, into_bnd, one_shot, sat;
    // next count, terminal pulse and one-shot state; priority load > start > en
    always_comb begin
        one_shot = mode == 2'b10;
        sat      = mode == 2'b01;
        at_bnd   = up ? count_q == MAX_VAL : count_q == '0;
        step     = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        into_bnd = step == (up ? MAX_VAL : '0);
        count_d  = count_q;
        state_d  = one_shot ? state_q : IDLE;
        tc_d     = 1'b0;
        if (load) begin
            count_d = load_val > MAX_VAL ? MAX_VAL : load_val;
            state_d = IDLE;
        end else if (one_shot) begin
            case (state_q)
                IDLE: state_d = start ? RUN : IDLE;
                RUN: begin
                    if (en && at_bnd) begin
                        state_d = DONE;
                    end else if (en) begin
                        count_d = step;
                        tc_d    = into_bnd;
                        state_d = into_bnd ? DONE : RUN;
                    end
                end
                DONE: begin
                    if (start) begin
                        count_d = up ? '0 : MAX_VAL;
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (en) begin
            count_d = at_bnd ? (sat ? count_q : (up ? '0 : MAX_VAL)) : step;
            tc_d    = !at_bnd && into_bnd;
        end
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end
    // state and registered outputs, cleared asynchronously
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            count_q <= RESET_VAL;
            state_q <= IDLE;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule
